kernel_loader: RTL and testbench
================================

// Module: kernel_loader
// PURPOSE
//  Write-side sequencer for the 16-channel kernel coefficient store (16 banks x 18 words).
//  Accepts a valid/ready stream of coefficients and converts it into write address,
//  broadcast write data and one-hot per-bank write enables.
//  Sits between the host/DMA input stream and the kernel store's write port.
//  Flags when the full kernel set is resident.
// PARAMETERS
//  WIDTH     16  coefficient width in bits
//  NUM_CH    16  number of output-channel banks, i.e. one-hot write-enable lines
//  NUM_COEF  18  coefficients per bank; the write address runs 0..NUM_COEF-1
//  ADDR_W    5   write address width; requires 2**ADDR_W >= NUM_COEF
// PORTS
//  clk                 in   1        single clock, all logic rising-edge
//  reset               in   1        synchronous, active-high
//  start               in   1        1-cycle pulse: begin full reload; honoured only in IDLE
//  din                 in   WIDTH    coefficient stream data
//  din_valid           in   1        stream valid
//  din_ready           out  1        stream ready
//  KERNEL_write_addr   out  ADDR_W   coefficient index to write
//  KERNEL_din          out  WIDTH    write data, broadcast to all banks
//  KERNEL_we           out  NUM_CH   one-hot bank write enable
//  busy                out  1        high in LOAD and FINISH
//  done                out  1        1-cycle pulse when the last word is written
//  kernel_valid        out  1        full kernel set resident; safe to read
// BEHAVIOUR
//  Reset: every output is 0, state IDLE, counters 0. Reset mid-load abandons the load,
//   leaves partial contents in the store and keeps kernel_valid=0.
//  FSM states: IDLE, LOAD, FINISH.
//   IDLE -> LOAD on start=1. Entering LOAD clears kernel_valid and zeroes ch_cnt and coef_cnt.
//   LOAD -> FINISH on the handshake of the word with ch_cnt=NUM_CH-1 and coef_cnt=NUM_COEF-1.
//   FINISH -> IDLE unconditionally after 1 cycle. done=1 during FINISH.
//   kernel_valid goes 1 in the cycle after FINISH.
//  start is ignored in LOAD and FINISH; no restart, no queueing.
//  din_ready = (state==LOAD). It is a function of state only and never depends on din_valid.
//   din_valid in IDLE or FINISH is ignored; nothing is consumed.
//  Handshake: a word transfers when din_valid & din_ready. Stalls of any length are allowed.
//  Stream order is channel-fastest: word k goes to bank k%NUM_CH at address k/NUM_CH.
//  Latency: the write outputs are registered, 1 cycle after the transfer.
//   KERNEL_we = one-hot(ch_cnt), KERNEL_write_addr = coef_cnt, KERNEL_din = din.
//   In any cycle without a transfer, KERNEL_we = 0. Addr and din hold their last value.
//  Counters: ch_cnt increments per transfer and wraps NUM_CH-1 -> 0.
//   On that wrap, coef_cnt increments.
//   coef_cnt never exceeds NUM_COEF-1; values NUM_COEF..2**ADDR_W-1 are never driven.
//  The last word's we is asserted in the FINISH cycle, coincident with done.
//  KERNEL_we has at most one bit set in any cycle.
//  Exactly NUM_CH*NUM_COEF (288) writes occur per load.
//  Consumers may read only while kernel_valid=1. The loader does not block reads;
//   that interlock is the consumer's responsibility.
// STRUCTURE
//  Shared package kernel_pkg holds:
//   NUM_CH, NUM_COEF, KADDR_W constants;
//   typedef enum logic [1:0] {IDLE, LOAD, FINISH} kload_state_t;
//   typedef logic [NUM_CH-1:0] kwe_t.
//  No sub-module. The one-hot decode is an inline shift (1 << ch_cnt).
//  At top level, KERNEL_din fans out to all KERNEL_din_N ports of the store and
//   KERNEL_we[N] drives KERNEL_we_N.
// TESTING
//  1 Reset, then start with din_valid held high and din=k for k=0..287
//     -> 288 we pulses; bank c, addr a receives 16a+c;
//     done at cycle 290 after start; kernel_valid rises at cycle 291.
//  2 Same stream with din_valid toggled 1,0,0,1,...
//     -> identical store contents; KERNEL_we=0 in every cycle after a valid=0 cycle;
//     done is delayed accordingly.
//  3 start pulsed again at word 100 -> ignored; the load completes normally with 288 writes.
//  4 reset asserted at word 150 -> all outputs 0 on the next cycle, kernel_valid=0.
//     A new start reloads from bank 0, addr 0.
//  5 din_valid=1 while IDLE (no start) -> din_ready=0, KERNEL_we=0, nothing consumed.
//  6 Load completes, then start again -> kernel_valid drops to 0 the cycle after start;
//     second load overwrites all 288 words with new data; kernel_valid returns after done.

Source files
------------

// File: rtl/kernel_pkg.sv
// Shared definitions for the kernel coefficient store write path.
//   NUM_CH / NUM_COEF / KADDR_W / KWIDTH : store geometry and word width
//   kload_state_t                        : loader sequencer states
//   kwe_t                                : one-hot bank write-enable vector
package kernel_pkg;
  localparam int unsigned NUM_CH   = 16;
  localparam int unsigned NUM_COEF = 18;
  localparam int unsigned KADDR_W  = 5;
  localparam int unsigned KWIDTH   = 16;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} kload_state_t;

  typedef logic [NUM_CH-1:0] kwe_t;
endpackage

// File: rtl/kernel_loader_if.sv
// Coefficient stream plus kernel-store write port.
//   din / din_valid / din_ready : valid/ready input stream
//   KERNEL_write_addr           : coefficient index being written
//   KERNEL_din                  : write data broadcast to every bank
//   KERNEL_we                   : one-hot bank write enable
// master = loader side, slave = stream source / store side.
interface kernel_loader_if
  import kernel_pkg::*;
#(
  parameter int unsigned WIDTH  = KWIDTH,
  parameter int unsigned NUM_CH = kernel_pkg::NUM_CH,
  parameter int unsigned ADDR_W = KADDR_W
);
  logic [WIDTH-1:0]  din;
  logic              din_valid;
  logic              din_ready;
  logic [ADDR_W-1:0] KERNEL_write_addr;
  logic [WIDTH-1:0]  KERNEL_din;
  logic [NUM_CH-1:0] KERNEL_we;

  modport master (
    input  din, din_valid,
    output din_ready, KERNEL_write_addr, KERNEL_din, KERNEL_we
  );

  modport slave (
    output din, din_valid,
    input  din_ready, KERNEL_write_addr, KERNEL_din, KERNEL_we
  );
endinterface

// File: rtl/kernel_loader.sv
// Write-side sequencer for the kernel coefficient store (NUM_CH banks x
// NUM_COEF words). Converts a channel-fastest coefficient stream into a
// registered write address, broadcast write data and one-hot bank enables,
// and flags when a complete kernel set is resident.
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   start        : one-cycle pulse, begins a full reload (IDLE only)
//   bus          : stream in + store write port (kernel_loader_if.master)
//   busy         : high in LOAD and FINISH
//   done         : one-cycle pulse, coincident with the last write enable
//   kernel_valid : full kernel set resident; consumers may read
module kernel_loader #(
  parameter int unsigned WIDTH    = kernel_pkg::KWIDTH,
  parameter int unsigned NUM_CH   = kernel_pkg::NUM_CH,
  parameter int unsigned NUM_COEF = kernel_pkg::NUM_COEF,
  parameter int unsigned ADDR_W   = kernel_pkg::KADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  kernel_loader_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic                   kernel_valid
);
  import kernel_pkg::*;

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [NUM_CH-1:0] WE_ONE   = NUM_CH'(1);
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [ADDR_W-1:0] COEF_LAST = ADDR_W'(NUM_COEF - 1);

  kload_state_t      state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] coef_q, coef_d;
  logic              kv_q, kv_d;
  logic [NUM_CH-1:0] we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]  din_q, din_d;
  logic              xfer;

  assign xfer = bus.din_valid && (state_q == LOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      coef_q  <= '0;
      kv_q    <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      coef_q  <= coef_d;
      kv_q    <= kv_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    coef_d  = coef_q;
    kv_d    = kv_q;
    we_d    = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          ch_d    = '0;
          coef_d  = '0;
          kv_d    = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          we_d   = WE_ONE << ch_q;
          addr_d = coef_q;
          din_d  = bus.din;
          if (ch_q == CH_LAST) begin
            ch_d = '0;
            // Final word: the write lands in the FINISH cycle alongside done.
            if (coef_q == COEF_LAST) begin
              coef_d  = '0;
              state_d = FINISH;
            end else begin
              coef_d = coef_q + ADDR_W'(1);
            end
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
        kv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.din_ready         = (state_q == LOAD);
  assign bus.KERNEL_we         = we_q;
  assign bus.KERNEL_write_addr = addr_q;
  assign bus.KERNEL_din        = din_q;
  assign busy                  = (state_q != IDLE);
  assign done                  = (state_q == FINISH);
  assign kernel_valid          = kv_q;
endmodule

// File: tb/tb_kernel_loader.sv
// Self-checking bench for kernel_loader: scoreboard of expected writes,
// behavioural model of ready/busy/done/kernel_valid, and a shadow store
// rebuilt from the DUT write port for end-of-load content checks.
module tb_kernel_loader;
  import kernel_pkg::*;

  localparam int TOTAL = 288;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy, done, kernel_valid;

  kernel_loader_if #(.WIDTH(16), .NUM_CH(16), .ADDR_W(5)) bus ();

  kernel_loader #(
    .WIDTH(16), .NUM_CH(16), .NUM_COEF(18), .ADDR_W(5)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .bus(bus),
    .busy(busy), .done(done), .kernel_valid(kernel_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bank;
    int          addr;
    logic [15:0] data;
  } wr_t;

  wr_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Model of the sequencer as seen from outside.
  bit m_ld, m_fin, m_kv;
  int m_cnt;

  // Event bookkeeping from the DUT outputs.
  logic [31:0] store [16][18];
  int wr_cnt, done_cnt;
  int cyc_no, done_at, kv_at;
  bit track;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic observe();
    int bank;
    wr_t w;
    check_eq("din_ready", 32'(bus.din_ready), 32'(m_ld));
    check_eq("busy", 32'(busy), 32'(m_ld || m_fin));
    check_eq("done", 32'(done), 32'(m_fin));
    check_eq("kernel_valid", 32'(kernel_valid), 32'(m_kv));
    check_eq("we_onehot0", 32'($onehot0(bus.KERNEL_we)), 32'd1);
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check_eq("we", 32'(bus.KERNEL_we), 32'(kwe_t'(1) << w.bank));
      check_eq("addr", 32'(bus.KERNEL_write_addr), 32'(w.addr));
      check_eq("wdata", 32'(bus.KERNEL_din), 32'(w.data));
    end else begin
      check_eq("we_idle", 32'(bus.KERNEL_we), 32'd0);
    end
    if (bus.KERNEL_we != '0) begin
      wr_cnt++;
      bank = 0;
      for (int i = 0; i < 16; i++)
        if (bus.KERNEL_we[i]) bank = i;
      if (bus.KERNEL_write_addr < 5'd18)
        store[bank][bus.KERNEL_write_addr] = {16'h0, bus.KERNEL_din};
    end
    if (done) done_cnt++;
    if (track) begin
      if (done && done_at == 0) done_at = cyc_no;
      if (kernel_valid && kv_at == 0) kv_at = cyc_no;
    end
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cyc(input logic st, input logic v, input logic [15:0] d);
    bit xfer, n_ld, n_fin, n_kv;
    int n_cnt;
    wr_t w;
    start         = st;
    bus.din_valid = v;
    bus.din       = d;
    xfer  = v && m_ld;
    n_ld  = m_ld;
    n_fin = 1'b0;
    n_cnt = m_cnt;
    n_kv  = m_kv;
    if (m_fin) n_kv = 1'b1;
    if (!m_ld && !m_fin && st) begin
      n_ld = 1'b1; n_cnt = 0; n_kv = 1'b0;
      cyc_no = 1;
    end
    if (xfer) begin
      w.bank = m_cnt % 16;
      w.addr = m_cnt / 16;
      w.data = d;
      exp_q.push_back(w);
      n_cnt = m_cnt + 1;
      if (m_cnt == TOTAL - 1) begin n_ld = 1'b0; n_fin = 1'b1; end
    end
    @(posedge clk); #1;
    cyc_no++;
    m_ld = n_ld; m_fin = n_fin; m_cnt = n_cnt; m_kv = n_kv;
    observe();
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; bus.din_valid = 1'b0; bus.din = 16'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    m_ld = 0; m_fin = 0; m_kv = 0; m_cnt = 0;
    check_eq("rst_we", 32'(bus.KERNEL_we), 32'd0);
    check_eq("rst_addr", 32'(bus.KERNEL_write_addr), 32'd0);
    check_eq("rst_din", 32'(bus.KERNEL_din), 32'd0);
    check_eq("rst_ready", 32'(bus.din_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_kv", 32'(kernel_valid), 32'd0);
  endtask

  // mode 0: valid held high; mode 1: valid pattern 1,0,0 repeating.
  task automatic run_load(input int mode, input logic [15:0] key,
                          input int restart_at, input int reset_at, output bit aborted);
    logic v, st;
    aborted  = 1'b0;
    wr_cnt   = 0;
    done_cnt = 0;
    for (int c = 0; c < 16; c++)
      for (int a = 0; a < 18; a++)
        store[c][a] = 32'hFFFF_FFFF;
    cyc(1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 3000 && m_ld; n++) begin
      if (m_cnt == reset_at) begin
        do_reset();
        aborted = 1'b1;
        break;
      end
      v  = (mode == 0) ? 1'b1 : ((n % 3) == 0);
      st = (m_cnt == restart_at);
      cyc(st, v, 16'(m_cnt) ^ key);
    end
    if (!aborted) begin
      cyc(1'b0, 1'b0, 16'h0);
      check_eq("write_count", 32'(wr_cnt), 32'(TOTAL));
      check_eq("done_pulses", 32'(done_cnt), 32'd1);
      for (int c = 0; c < 16; c++)
        for (int a = 0; a < 18; a++)
          check_eq("store", store[c][a], {16'h0, 16'(16 * a + c) ^ key});
    end
  endtask

  initial begin
    bit ab;
    track = 0; cyc_no = 0; done_at = 0; kv_at = 0;
    reset = 1'b1; start = 1'b0; bus.din_valid = 1'b0; bus.din = 16'h0;
    repeat (2) @(posedge clk);
    do_reset();

    // Valid while idle: nothing consumed.
    wr_cnt = 0;
    repeat (4) cyc(1'b0, 1'b1, 16'hDEAD);
    check_eq("idle_writes", 32'(wr_cnt), 32'd0);

    // Full load, valid held high; start cycle counts as cycle 1.
    track = 1;
    run_load(0, 16'h0000, -1, -1, ab);
    track = 0;
    check_eq("done_cycle", 32'(done_at), 32'd290);
    check_eq("kv_cycle", 32'(kv_at), 32'd291);

    // Stalled stream.
    run_load(1, 16'h0000, -1, -1, ab);

    // start during load is ignored.
    run_load(0, 16'h0000, 100, -1, ab);

    // Reset mid-load, then reload from bank 0 / addr 0.
    run_load(0, 16'h0000, -1, 150, ab);
    check_eq("reset_aborted", 32'(ab), 32'd1);
    run_load(0, 16'h1234, -1, -1, ab);

    // Reload over a resident set with new data.
    check_eq("kv_before_reload", 32'(kernel_valid), 32'd1);
    run_load(1, 16'h5A5A, -1, -1, ab);

    repeat (2) cyc(1'b0, 1'b0, 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
